// File: rtl/wdt_ctrl_if.sv
// rtl/wdt_ctrl_if.sv - register bus between CPU side and the watchdog controller
interface wdt_ctrl_if;
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output we, output addr, output wdata, input rdata);
    modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/wdt_ctrl.sv
// rtl/wdt_ctrl.sv - bus-mapped watchdog timer controller with stretched reset request
module wdt_ctrl #(
    parameter int unsigned PRESCALE     = 1024,
    parameter logic [31:0] DEFAULT_LOAD = 32'h0000_FFFF,
    parameter int unsigned RST_HOLD     = 16,
    parameter logic [31:0] KICK_KEY     = 32'h5A5A_A5A5
) (
    input  logic       clk,
    input  logic       rst,
    wdt_ctrl_if.slave  bus,
    output logic       wdt_rst_req,
    output logic       irq_warn
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t        state;
    logic          warn_en;
    logic          warn;
    logic          to;
    logic [31:0]   load;
    logic [31:0]   count;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;

    logic        wr_ctrl, wr_load, wr_kick, wr_status;
    logic        kick_ok, tick, disable_req, timeout, set_warn;
    logic [31:0] count_dec;

    // Decode bus writes and the per-cycle events that drive the FSM and status bits
    always_comb begin
        wr_ctrl     = bus.cs && bus.we && (bus.addr == 2'd0);
        wr_load     = bus.cs && bus.we && (bus.addr == 2'd1);
        wr_kick     = bus.cs && bus.we && (bus.addr == 2'd2);
        wr_status   = bus.cs && bus.we && (bus.addr == 2'd3);
        kick_ok     = wr_kick && (bus.wdata == KICK_KEY);
        count_dec   = count - 32'd1;
        tick        = (state == RUN) && (presc == PRESC_MAX);
        disable_req = (state == RUN) && wr_ctrl && !bus.wdata[0];
        // A bad kick times out at once; a valid kick beats a same-cycle zero tick
        timeout     = (state == RUN) &&
                      ((wr_kick && !kick_ok) ||
                       (!wr_kick && !disable_req && tick && (count == 32'd0)));
        set_warn    = (state == RUN) && !wr_kick && !disable_req && tick &&
                      (count != 32'd0) && (count_dec == (load >> 1));
    end

    // Register read mux; reads have no side effects
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'd0:    bus.rdata = {30'd0, warn_en, state != IDLE};
            2'd1:    bus.rdata = load;
            2'd2:    bus.rdata = count;
            default: bus.rdata = {30'd0, to, warn};
        endcase
    end

    // Main FSM: enable, prescaled countdown, kicks and the reset-request hold window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            warn_en     <= 1'b0;
            count       <= DEFAULT_LOAD;
            presc       <= '0;
            hold_cnt    <= '0;
            wdt_rst_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ctrl) begin
                        warn_en <= bus.wdata[1];
                        if (bus.wdata[0]) begin
                            count <= load;
                            presc <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (disable_req) begin
                        warn_en <= bus.wdata[1];
                        state   <= IDLE;
                    end else if (kick_ok) begin
                        count <= load;
                        presc <= '0;
                    end else if (timeout) begin
                        hold_cnt    <= HOLD_INIT;
                        wdt_rst_req <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        if (wr_ctrl) begin
                            warn_en <= bus.wdata[1];
                        end
                        if (tick) begin
                            presc <= '0;
                            count <= count_dec;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Counter frozen; CPU must re-arm once the reboot completes
                    if (hold_cnt == HW'(1)) begin
                        wdt_rst_req <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: begin
                    wdt_rst_req <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // LOAD register; zero is promoted to one so a reload always allows a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load <= DEFAULT_LOAD;
        end else if (wr_load) begin
            load <= (bus.wdata == 32'd0) ? 32'd1 : bus.wdata;
        end
    end

    // Sticky status with write-1-to-clear; a same-edge set overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn     <= 1'b0;
            to       <= 1'b0;
            irq_warn <= 1'b0;
        end else begin
            warn     <= set_warn | (warn & ~(wr_status & bus.wdata[0]));
            to       <= timeout  | (to   & ~(wr_status & bus.wdata[1]));
            irq_warn <= warn & warn_en;
        end
    end
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb/tb_wdt_ctrl.sv - self-checking bench for wdt_ctrl
module tb_wdt_ctrl;
    localparam int unsigned P     = 4;
    localparam int unsigned HOLDN = 8;
    localparam logic [31:0] DEFL  = 32'h0000_FFFF;
    localparam logic [31:0] KEY   = 32'h5A5A_A5A5;

    logic clk;
    logic rst;
    logic wdt_rst_req;
    logic irq_warn;
    int   n_checks;
    int   n_errors;

    wdt_ctrl_if bus();

    wdt_ctrl #(.PRESCALE(P), .DEFAULT_LOAD(DEFL), .RST_HOLD(HOLDN), .KICK_KEY(KEY)) dut (
        .clk(clk), .rst(rst), .bus(bus), .wdt_rst_req(wdt_rst_req), .irq_warn(irq_warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count derived from cycles elapsed since the last reload
    int          m_state;
    int unsigned m_load, m_leff, m_since, m_frozen, m_hold;
    bit          m_warn, m_to, m_warn_en, m_irq;

    task automatic model_reset();
        m_state = 0; m_load = DEFL; m_leff = DEFL; m_since = 0; m_frozen = DEFL;
        m_hold = 0; m_warn = 0; m_to = 0; m_warn_en = 0; m_irq = 0;
    endtask

    function automatic int unsigned model_count();
        if (m_state == 1) return m_leff - m_since / P;
        return m_frozen;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_warn_en, m_state != 0};
            2'd1:    return m_load;
            2'd2:    return model_count();
            default: return {30'd0, m_to, m_warn};
        endcase
    endfunction

    task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
        int unsigned cnt_now, k;
        bit new_warn, new_to, tmo;
        cnt_now  = model_count();
        new_warn = m_warn && !(w && a == 2'd3 && d[0]);
        new_to   = m_to && !(w && a == 2'd3 && d[1]);
        m_irq    = m_warn && m_warn_en;
        tmo      = 0;
        case (m_state)
            0: if (w && a == 2'd0) begin
                m_warn_en = d[1];
                if (d[0]) begin m_state = 1; m_leff = m_load; m_since = 0; end
            end
            1: if (w && a == 2'd0 && !d[0]) begin
                m_warn_en = d[1]; m_frozen = cnt_now; m_state = 0;
            end else if (w && a == 2'd2) begin
                if (d == KEY) begin m_leff = m_load; m_since = 0; end
                else tmo = 1;
            end else begin
                if (w && a == 2'd0) m_warn_en = d[1];
                m_since++;
                if (m_since % P == 0) begin
                    k = m_since / P;
                    if (k > m_leff) tmo = 1;
                    else if (m_leff - k == (m_load >> 1)) new_warn = 1;
                end
            end
            default: begin
                m_hold--;
                if (m_hold == 0) m_state = 0;
            end
        endcase
        if (tmo) begin new_to = 1; m_frozen = cnt_now; m_hold = HOLDN; m_state = 2; end
        m_warn = new_warn;
        m_to   = new_to;
        if (w && a == 2'd1) m_load = (d == 0) ? 1 : d;
    endtask

    task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = w; bus.we = w; bus.addr = a; bus.wdata = d;
        model_edge(w, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd0; exp_rd[1] = DEFL; exp_rd[2] = DEFL; exp_rd[3] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            n_checks++;
            if (bus.rdata !== exp_rd[a]) begin
                n_errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, bus.rdata, exp_rd[a]);
            end
        end
        n_checks++;
        if (wdt_rst_req !== 1'b0 || irq_warn !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs: got req=%b irq=%b expected 0 0", wdt_rst_req, irq_warn);
        end
    endtask

    task automatic test_timeout();
        step(1, 2'd1, 32'd3);
        step(1, 2'd0, 32'd3);
        for (int n = 1; n <= 24; n++) begin
            step(0, 2'd3, 32'd0);
            n_checks++;
            if (wdt_rst_req !== (n >= 16 && n <= 23)) begin
                n_errors++; $display("FAIL timeout_req@%0d: got %b expected %b", n, wdt_rst_req, (n >= 16 && n <= 23));
            end
            if (n == 7 || n == 8) begin
                n_checks++;
                if (bus.rdata[0] !== (n == 8)) begin
                    n_errors++; $display("FAIL timeout_warn@%0d: got %b expected %b", n, bus.rdata[0], (n == 8));
                end
            end
            if (n == 8 || n == 9) begin
                n_checks++;
                if (irq_warn !== (n == 9)) begin
                    n_errors++; $display("FAIL timeout_irq@%0d: got %b expected %b", n, irq_warn, (n == 9));
                end
            end
        end
        n_checks++;
        if (bus.rdata !== 32'd3) begin
            n_errors++; $display("FAIL timeout_status: got %h expected 3", bus.rdata);
        end
        step(0, 2'd0, 32'd0);
        n_checks++;
        if (bus.rdata[0] !== 1'b0) begin
            n_errors++; $display("FAIL timeout_en_cleared: got %b expected 0", bus.rdata[0]);
        end
        step(1, 2'd3, 32'd3);
    endtask

    task automatic test_kick_periodic();
        int bad;
        bad = 0;
        step(1, 2'd0, 32'd1);
        for (int i = 1; i <= 200; i++) begin
            if (i % 12 == 0) step(1, 2'd2, KEY);
            else step(0, 2'd2, 32'd0);
            if (wdt_rst_req !== 1'b0 || bus.rdata < 32'd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL kick_periodic: got %0d bad cycles expected 0", bad);
        end
        step(1, 2'd0, 32'd0);
        step(1, 2'd3, 32'd3);
    endtask

    task automatic test_bad_kick();
        int dropped;
        step(1, 2'd0, 32'd1);
        for (int n = 1; n <= 4; n++) step(0, 2'd2, 32'd0);
        n_checks++;
        if (bus.rdata !== 32'd2) begin
            n_errors++; $display("FAIL badkick_pre_count: got %h expected 2", bus.rdata);
        end
        step(1, 2'd2, 32'h1234_5678);
        n_checks++;
        if (wdt_rst_req !== 1'b1) begin
            n_errors++; $display("FAIL badkick_req: got %b expected 1", wdt_rst_req);
        end
        step(0, 2'd3, 32'd0);
        n_checks++;
        if (bus.rdata[1] !== 1'b1) begin
            n_errors++; $display("FAIL badkick_to: got %b expected 1", bus.rdata[1]);
        end
        dropped = 0;
        for (int n = 0; n < 20 && dropped == 0; n++) begin
            step(0, 2'd3, 32'd0);
            if (wdt_rst_req === 1'b0) dropped = 1;
        end
        n_checks++;
        if (dropped != 1) begin
            n_errors++; $display("FAIL badkick_hold_timeout: got req=%b expected 0 within 20 cycles", wdt_rst_req);
        end
        step(1, 2'd3, 32'd3);
    endtask

    task automatic test_kick_at_zero();
        step(1, 2'd0, 32'd1);
        for (int n = 1; n <= 15; n++) step(0, 2'd2, 32'd0);
        n_checks++;
        if (bus.rdata !== 32'd0) begin
            n_errors++; $display("FAIL kickzero_pre_count: got %h expected 0", bus.rdata);
        end
        step(1, 2'd2, KEY);
        n_checks++;
        if (bus.rdata !== 32'd3 || wdt_rst_req !== 1'b0) begin
            n_errors++; $display("FAIL kickzero: got count=%h req=%b expected 3 0", bus.rdata, wdt_rst_req);
        end
        for (int n = 0; n < 6; n++) begin
            step(0, 2'd3, 32'd0);
            n_checks++;
            if (wdt_rst_req !== 1'b0 || bus.rdata[1] !== 1'b0) begin
                n_errors++; $display("FAIL kickzero_after: got req=%b to=%b expected 0 0", wdt_rst_req, bus.rdata[1]);
            end
        end
        step(1, 2'd0, 32'd0);
        step(1, 2'd3, 32'd3);
    endtask

    task automatic test_load_zero();
        step(1, 2'd1, 32'd0);
        step(0, 2'd1, 32'd0);
        n_checks++;
        if (bus.rdata !== 32'd1) begin
            n_errors++; $display("FAIL loadzero_read: got %h expected 1", bus.rdata);
        end
        step(1, 2'd0, 32'd1);
        for (int n = 1; n <= 10; n++) begin
            step(0, 2'd2, 32'd0);
            n_checks++;
            if (wdt_rst_req !== (n >= 8)) begin
                n_errors++; $display("FAIL loadzero_req@%0d: got %b expected %b", n, wdt_rst_req, (n >= 8));
            end
        end
    endtask

    task automatic test_reset_in_hold();
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd0; exp_rd[1] = DEFL; exp_rd[2] = DEFL; exp_rd[3] = 32'd0;
        #2;
        rst = 1'b1;
        bus.cs = 1'b0; bus.we = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (wdt_rst_req !== 1'b0) begin
            n_errors++; $display("FAIL hold_reset_req: got %b expected 0", wdt_rst_req);
        end
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            n_checks++;
            if (bus.rdata !== exp_rd[a]) begin
                n_errors++; $display("FAIL hold_reset_reg%0d: got %h expected %h", a, bus.rdata, exp_rd[a]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] d;
        bit          w;
        int unsigned r;
        step(1, 2'd1, $urandom_range(1, 4));
        step(1, 2'd0, {30'd0, 1'b1, 1'b1});
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            w = 1'b1;
            a = 2'($urandom_range(0, 3));
            if (r < 8)       begin a = 2'd2; d = KEY; end
            else if (r < 9)  begin a = 2'd2; d = $urandom; end
            else if (r < 14) begin a = 2'd0; d = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)}; end
            else if (r < 17) begin a = 2'd1; d = $urandom_range(0, 5); end
            else if (r < 20) begin a = 2'd3; d = {30'd0, 2'($urandom_range(0, 3))}; end
            else             begin w = 1'b0; d = $urandom; end
            step(w, a, d);
            n_checks++;
            if (wdt_rst_req !== (m_state == 2) || irq_warn !== m_irq || bus.rdata !== model_rd(a)) begin
                n_errors++;
                $display("FAIL random@%0d: got req=%b irq=%b rd[%0d]=%h expected %b %b %h",
                         i, wdt_rst_req, irq_warn, a, bus.rdata, (m_state == 2), m_irq, model_rd(a));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_timeout();
        test_kick_periodic();
        test_bad_kick();
        test_kick_at_zero();
        test_load_zero();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Bus-mapped watchdog timer controller sitting directly upstream of `watchDog`. The CPU configures and kicks it through four word registers on the system bus. On expiry it drives a stretched reset request into the `watchDog` reset input. It is clocked by the system clock and reset only by the board-level reset, never by the reset it requests, so its sticky timeout status survives a watchdog reboot.

## Interface
Parameters:
- `PRESCALE`, 1024: clk cycles per counter tick (≥1).
- `DEFAULT_LOAD`, 32'h0000_FFFF: reset value of LOAD.
- `RST_HOLD`, 16: cycles `wdt_rst_req` stays high per timeout (≥1).
- `KICK_KEY`, 32'h5A5A_A5A5: valid kick value.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: bus select for this block.
- `we` in 1: write strobe, qualified by `cs`.
- `addr` in 2: word register index.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational from `addr`.
- `wdt_rst_req` out 1: reset request to `watchDog`.
- `irq_warn` out 1: level interrupt, high when STATUS.WARN=1 and CTRL.WARN_EN=1.

## Operation
Registers:
- 0 CTRL: bit0 EN, bit1 WARN_EN. Other bits read 0.
- 1 LOAD: reload value. A write of 0 stores 1.
- 2 KICK/COUNT: a write reloads the counter. Reads return the current count.
- 3 STATUS: bit0 WARN, bit1 TO (sticky). Both are write-1-to-clear.

States:
- IDLE (EN=0): counter and prescaler frozen. A write of CTRL with EN=1 loads count=LOAD, clears the prescaler, and moves to RUN.
- RUN: the prescaler counts 0..PRESCALE-1. Its wrap is a tick.
  - On a tick with count>0, the count decrements.
  - If the new count equals LOAD>>1, WARN is set.
  - On a tick with count==0, the block sets TO, loads the hold counter with RST_HOLD, and moves to HOLD.
- HOLD: `wdt_rst_req`=1. The counter is frozen, and kicks and CTRL writes are ignored.
  - When the hold counter expires, the block clears EN and returns to IDLE. The CPU must re-arm after reboot.

Kick rules, applied in RUN:
- Write of KICK_KEY: count=LOAD and the prescaler is cleared. WARN is not cleared.
- Write of any other value: immediate timeout, same actions as a count==0 tick.
- Kicks while in IDLE are ignored.

Other register rules:
- In RUN, writing EN=0 returns to IDLE with no timeout.
- A LOAD write in RUN takes effect only at the next kick or enable.

Simultaneous events:
- Valid kick and tick at count==0 in the same cycle: the kick wins and no timeout occurs.
- W1C write and set on the same edge: set wins.

## Timing
- Reset values: CTRL=0, LOAD=DEFAULT_LOAD, count=DEFAULT_LOAD, prescaler=0, STATUS=0, state IDLE, `wdt_rst_req`=0, `irq_warn`=0.
- `rdata` reflects register state after the most recent edge. There are no read side effects.
- Writes take effect on the edge where `cs`&`we` are sampled high.
- If the enable edge is E, the first tick is at E+PRESCALE and timeout is at E+(LOAD+1)·PRESCALE.
- `wdt_rst_req` rises on the timeout edge T and falls at T+RST_HOLD. It is registered and glitch-free.
- `irq_warn` is registered and follows WARN one edge after WARN sets or clears.
- When `rst` asserts mid-operation, all state returns immediately to the reset values, including dropping `wdt_rst_req`.

## Test plan
- PRESCALE=4, LOAD=3, RST_HOLD=8, enable at edge 0:
  - Required: WARN sets at edge 8 and `wdt_rst_req` is high for edges 16–23.
  - Required: STATUS reads 2'b11 and CTRL.EN reads 0 after edge 24.
- Same setup, write KICK_KEY every 12 cycles for 200 cycles:
  - Required: `wdt_rst_req` never rises and COUNT never reads below 1.
- In RUN at count=2, write KICK=32'h1234_5678:
  - Required: `wdt_rst_req` rises on that edge and TO=1.
- Valid kick written on the same edge as the count==0 tick:
  - Required: count=LOAD and no reset request.
- LOAD write of 0 then enable with PRESCALE=4:
  - Required: LOAD reads 1 and the timeout occurs 8 cycles after enable.
- Assert `rst` during HOLD:
  - Required: `wdt_rst_req` drops immediately and all registers read their reset values, with STATUS=0 and LOAD=DEFAULT_LOAD.
